// File: rtl/mips_fetch_defs.sv
// Shared encodings for the fetch stage: control types as emitted by mips_decode,
// fetch FSM state codes and default address constants.
package mips_fetch_defs;

  typedef enum logic [1:0] {
    CT_SEQ = 2'b00,
    CT_BR  = 2'b01,
    CT_J   = 2'b10,
    CT_JR  = 2'b11
  } ctrl_type_e;

  typedef enum logic [1:0] {
    S_REQ  = 2'b00,
    S_WAIT = 2'b01,
    S_HOLD = 2'b10
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0180;

endpackage

// File: rtl/mips_next_pc.sv
// Combinational next-PC selection for a retiring instruction: sequential, branch,
// jump, jump-register, with exceptions and misaligned jr targets vectored away.
module mips_next_pc
  import mips_fetch_defs::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic [31:0] pc_plus4,
  input  logic [1:0]  control_type,
  input  logic        except,
  input  logic [15:0] imm16,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] br_offset;
  assign br_offset = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    next_pc    = pc_plus4;
    misaligned = 1'b0;
    if (except) begin
      next_pc = EXC_VECTOR;
    end else begin
      unique case (control_type)
        CT_SEQ: next_pc = pc_plus4;
        CT_BR:  next_pc = pc_plus4 + br_offset;
        CT_J:   next_pc = {pc_plus4[31:28], jump_index, 2'b00};
        CT_JR: begin
          if (jr_target[1:0] != 2'b00) begin
            next_pc    = EXC_VECTOR;
            misaligned = 1'b1;
          end else begin
            next_pc = jr_target;
          end
        end
        default: next_pc = pc_plus4;
      endcase
    end
  end

endmodule

// File: rtl/mips_fetch.sv
// Instruction-fetch stage: owns PC and instruction register, fetches over a
// variable-latency req/ack memory port and advances PC when execute retires.
module mips_fetch
  import mips_fetch_defs::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  control_type,
  input  logic        except,
  input  logic        retire,
  input  logic [15:0] imm16,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_fault,
  output logic [31:0] retired_count
);

  fetch_state_e state_q;
  logic [31:0]  next_pc;
  logic         misaligned;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = {pc[31:2], 2'b00};

  mips_next_pc #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_next_pc (
    .pc_plus4    (pc_plus4),
    .control_type(control_type),
    .except      (except),
    .imm16       (imm16),
    .jump_index  (jump_index),
    .jr_target   (jr_target),
    .next_pc     (next_pc),
    .misaligned  (misaligned)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_REQ;
      pc            <= RESET_PC;
      inst          <= '0;
      inst_valid    <= 1'b0;
      imem_req      <= 1'b0;
      fetch_fault   <= 1'b0;
      retired_count <= '0;
    end else begin
      fetch_fault <= 1'b0;
      unique case (state_q)
        S_REQ: begin
          // Right after reset the request is still low; raise it before acks count.
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            inst       <= imem_rdata;
            inst_valid <= 1'b1;
            imem_req   <= 1'b0;
            state_q    <= S_HOLD;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            inst       <= imem_rdata;
            inst_valid <= 1'b1;
            imem_req   <= 1'b0;
            state_q    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (retire) begin
            pc            <= next_pc;
            fetch_fault   <= misaligned;
            retired_count <= retired_count + 32'd1;
            inst_valid    <= 1'b0;
            imem_req      <= 1'b1;
            state_q       <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_fetch.sv
// Scoreboard bench for mips_fetch: directed scenarios followed by random
// instruction streams checked against a behavioural next-PC model.
module tb_mips_fetch;
  import mips_fetch_defs::*;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] EXC_PC = 32'h8000_0180;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  control_type;
  logic        except;
  logic        retire;
  logic [15:0] imm16;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_fault;
  logic [31:0] retired_count;

  mips_fetch dut (
    .clock        (clock),
    .reset        (reset),
    .control_type (control_type),
    .except       (except),
    .retire       (retire),
    .imm16        (imm16),
    .jump_index   (jump_index),
    .jr_target    (jr_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .fetch_fault  (fetch_fault),
    .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] count;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          fault_cycle = -1;
  logic [31:0] m_pc;
  logic [31:0] m_count;
  logic [31:0] m_inst;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference next-PC rule, computed with plain arithmetic.
  function automatic void model_next(input logic [31:0] p, input logic [1:0] ct,
                                     input logic [15:0] imm, input logic [25:0] ji,
                                     input logic [31:0] jr, input logic exc,
                                     output logic [31:0] nxt, output bit flt);
    logic [31:0] seq;
    int          off;
    seq = p + 32'd4;
    flt = 1'b0;
    off = $signed(imm);
    if (exc) nxt = EXC_PC;
    else if (ct == 2'd0) nxt = seq;
    else if (ct == 2'd1) nxt = seq + 32'(off * 4);
    else if (ct == 2'd2) nxt = (seq & 32'hF000_0000) | (32'(ji) * 32'd4);
    else if (jr % 32'd4 == 32'd0) nxt = jr;
    else begin
      nxt = EXC_PC;
      flt = 1'b1;
    end
  endfunction

  // Monitor: pops an expectation whenever a new instruction becomes valid.
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clock);
      check1("fault_pulse", fetch_fault, cyc == fault_cycle);
      if (inst_valid === 1'b1 && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_inst: got inst %h with no pending fetch", inst);
        end else begin
          e = exp_q.pop_front();
          check32("mon_inst", inst, e.inst);
          check32("mon_pc", pc, e.pc);
          check32("mon_pc_plus4", pc_plus4, e.pc + 32'd4);
          check32("mon_count", retired_count, e.count);
        end
      end
      prev_valid = (inst_valid === 1'b1);
    end
  end

  task automatic do_fetch(input int delay, input logic [31:0] rdata, input bit noise);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (imem_req !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got imem_req %b expected 1 within 20 cycles", imem_req);
      return;
    end
    for (int i = 0; i < delay; i++) begin
      check1("wait_req", imem_req, 1'b1);
      check32("wait_addr", imem_addr, m_pc);
      check1("wait_valid", inst_valid, 1'b0);
      retire = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clock);
    end
    retire = 1'b0;
    check32("ack_addr", imem_addr, m_pc);
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    m_inst     = rdata;
    exp_q.push_back('{pc: m_pc, inst: rdata, count: m_count});
    @(negedge clock);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check1("latency_valid", inst_valid, 1'b1);
  endtask

  task automatic do_retire(input int hold, input logic [1:0] ct, input logic [15:0] imm,
                           input logic [25:0] ji, input logic [31:0] jr, input logic exc);
    logic [31:0] nxt;
    bit          flt;
    for (int i = 0; i < hold; i++) begin
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      @(negedge clock);
    end
    imem_ack = 1'b0;
    check32("hold_inst", inst, m_inst);
    check1("hold_valid", inst_valid, 1'b1);
    check1("hold_req", imem_req, 1'b0);
    control_type = ct;
    imm16        = imm;
    jump_index   = ji;
    jr_target    = jr;
    except       = exc;
    retire       = 1'b1;
    model_next(m_pc, ct, imm, ji, jr, exc, nxt, flt);
    if (flt) fault_cycle = cyc + 1;
    m_pc    = nxt;
    m_count = m_count + 32'd1;
    @(negedge clock);
    retire       = 1'b0;
    control_type = 2'($urandom);
    except       = 1'($urandom);
    jr_target    = $urandom;
    check32("next_addr", imem_addr, m_pc);
    check32("count", retired_count, m_count);
    check1("req_after", imem_req, 1'b1);
    check1("valid_after", inst_valid, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] jr;
    logic [31:0] cnt_before;
    reset        = 1'b1;
    control_type = CT_SEQ;
    except       = 1'b0;
    retire       = 1'b0;
    imm16        = '0;
    jump_index   = '0;
    jr_target    = '0;
    imem_ack     = 1'b0;
    imem_rdata   = '0;
    m_pc         = RST_PC;
    m_count      = '0;
    m_inst       = '0;
    repeat (2) @(negedge clock);
    check1("rst_req", imem_req, 1'b0);
    check1("rst_valid", inst_valid, 1'b0);
    check32("rst_inst", inst, 32'h0);
    check32("rst_pc", pc, RST_PC);
    check32("rst_pc_plus4", pc_plus4, 32'h0040_0004);
    check32("rst_count", retired_count, 32'h0);
    check1("rst_fault", fetch_fault, 1'b0);
    reset = 1'b0;

    // Zero-wait fetch of the first instruction.
    do_fetch(0, 32'h2008_0005, 1'b0);
    check32("t1_inst", inst, 32'h2008_0005);
    do_retire(1, CT_JR, 16'h0, 26'h0, 32'h0040_0010, 1'b0);

    // Three wait cycles.
    do_fetch(3, 32'h1234_5678, 1'b0);
    do_retire(0, CT_BR, 16'hFFFF, 26'h0, 32'h0, 1'b0);
    check32("t3_br_back", imem_addr, 32'h0040_0010);
    do_fetch(1, $urandom, 1'b0);
    do_retire(0, CT_BR, 16'h0004, 26'h0, 32'h0, 1'b0);
    check32("t3_br_fwd", imem_addr, 32'h0040_0024);

    do_fetch(2, $urandom, 1'b0);
    do_retire(2, CT_J, 16'h0, 26'h010_0003, 32'h0, 1'b0);
    check32("t4_jump", imem_addr, 32'h0040_000C);
    do_fetch(0, $urandom, 1'b0);
    do_retire(0, CT_JR, 16'h0, 26'h0, 32'h0040_0102, 1'b0);
    check32("t4_jr_misaligned", imem_addr, EXC_PC);
    check1("t4_fault_high", fetch_fault, 1'b1);
    @(negedge clock);
    check1("t4_fault_low", fetch_fault, 1'b0);

    do_fetch(0, $urandom, 1'b0);
    cnt_before = retired_count;
    do_retire(1, CT_J, 16'h0, 26'h3FF_FFFF, 32'h0, 1'b1);
    check32("t5_except", imem_addr, EXC_PC);
    check32("t5_count", retired_count, cnt_before + 32'd1);

    // Reset while waiting on memory.
    do_fetch(0, $urandom, 1'b0);
    do_retire(0, CT_SEQ, 16'h0, 26'h0, 32'h0, 1'b0);
    repeat (2) @(negedge clock);
    check1("t6_waiting", imem_req, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    reset   = 1'b0;
    m_pc    = RST_PC;
    m_count = '0;
    check1("t6_req_drop", imem_req, 1'b0);
    check32("t6_pc", pc, RST_PC);
    check32("t6_count", retired_count, 32'h0);
    check1("t6_valid", inst_valid, 1'b0);
    do_fetch(1, 32'hCAFE_F00D, 1'b0);
    check32("t6_refetch_inst", inst, 32'hCAFE_F00D);

    for (int k = 0; k < 150; k++) begin
      jr = $urandom;
      if ($urandom_range(0, 1) == 1) jr[1:0] = 2'b00;
      do_retire($urandom_range(0, 3), 2'($urandom), 16'($urandom), 26'($urandom), jr,
                $urandom_range(0, 7) == 0);
      do_fetch($urandom_range(0, 4), $urandom, 1'b1);
    end

    @(negedge clock);
    check32("queue_drain", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
